// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_pkg
//  Purpose  : Shared definitions for the MIPS pipeline memory stage.
//             Holds the MemOp access size/extension encoding and the default
//             data memory depth.
//  Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int DM_WORDS_DEFAULT = 1024;

    // Codes 5-7 are unassigned and are treated as full-word accesses.
    typedef logic [2:0] memop_t;

    localparam memop_t MEMOP_W  = 3'd0;
    localparam memop_t MEMOP_H  = 3'd1;
    localparam memop_t MEMOP_HU = 3'd2;
    localparam memop_t MEMOP_B  = 3'd3;
    localparam memop_t MEMOP_BU = 3'd4;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
//  Module   : data_memory
//  Purpose  : Word-organised data memory with byte/half/word stores (read-
//             modify-write merge) and a combinational sign/zero-extending read.
//             Synchronous reset clears every word in one cycle.
//  Ports    : clk      - clock
//             reset    - synchronous active-high clear of the whole array
//             we_i     - commit a store at the next rising edge
//             memop_i  - access size / extension code
//             addr_i   - byte address (bits above the word index ignored)
//             wd_i     - store data (low byte/half used for narrow stores)
//             pc_i     - PC of the storing instruction (trace only)
//             rd_o     - extended load data
//  Revision : 1.0 - initial release
// ============================================================================
module data_memory
    import mips_pkg::*;
#(
    parameter int DM_WORDS = DM_WORDS_DEFAULT,
    parameter int DM_AW    = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we_i,
    input  memop_t      memop_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wd_i,
    input  logic [31:0] pc_i,
    output logic [31:0] rd_o
);

    logic [31:0]      mem_q [DM_WORDS];
    logic [DM_AW-1:0] idx;
    logic [31:0]      word;
    logic [15:0]      half;
    logic [7:0]       byte_sel;
    logic [31:0]      merged_d;

    // Upper address bits are dropped, so addresses wrap modulo DM_WORDS*4.
    assign idx      = addr_i[DM_AW+1:2];
    assign word     = mem_q[idx];
    assign half     = addr_i[1] ? word[31:16] : word[15:0];
    assign byte_sel = word[{addr_i[1:0], 3'b000} +: 8];

    // Narrow stores keep the untouched lanes of the current word.
    always_comb begin
        merged_d = wd_i;
        case (memop_i)
            MEMOP_H, MEMOP_HU: begin
                merged_d = word;
                if (addr_i[1]) merged_d[31:16] = wd_i[15:0];
                else           merged_d[15:0]  = wd_i[15:0];
            end
            MEMOP_B, MEMOP_BU: begin
                merged_d = word;
                merged_d[{addr_i[1:0], 3'b000} +: 8] = wd_i[7:0];
            end
            default: merged_d = wd_i;
        endcase
    end

    always_comb begin
        rd_o = word;
        case (memop_i)
            MEMOP_H:  rd_o = {{16{half[15]}}, half};
            MEMOP_HU: rd_o = {16'h0000, half};
            MEMOP_B:  rd_o = {{24{byte_sel[7]}}, byte_sel};
            MEMOP_BU: rd_o = {24'h000000, byte_sel};
            default:  rd_o = word;
        endcase
    end

    // Reset takes priority: a store pending on the reset edge is discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[idx] <= merged_d;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && we_i) begin
            $display("@%h: *%h <= %h", pc_i, {addr_i[31:2], 2'b00}, merged_d);
        end
    end
`endif

endmodule : data_memory
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Purpose  : MIPS memory stage: EX/MEM pipeline register, store-data
//             forwarding from W, and the data memory.
//  Ports    : clk, reset            - clock, synchronous active-high reset
//             AO_E/RT_E/PC_E/PCAdd8_E/A3_E/MemWrite_E/MemOp_E - from EX
//             ForwardRT_M, WD_W     - replace store data with the W value
//             DMout_M               - extended load data (combinational)
//             AO_M/PC_M/PCAdd8_M/A3_M - registered values to WB / hazard unit
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stage
    import mips_pkg::*;
#(
    parameter int DM_WORDS = DM_WORDS_DEFAULT,
    parameter int DM_AW    = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] AO_E,
    input  logic [31:0] RT_E,
    input  logic [31:0] PC_E,
    input  logic [31:0] PCAdd8_E,
    input  logic [4:0]  A3_E,
    input  logic        MemWrite_E,
    input  logic [2:0]  MemOp_E,
    input  logic        ForwardRT_M,
    input  logic [31:0] WD_W,
    output logic [31:0] DMout_M,
    output logic [31:0] AO_M,
    output logic [31:0] PC_M,
    output logic [31:0] PCAdd8_M,
    output logic [4:0]  A3_M
);

    logic [31:0] ao_q, rt_q, pc_q, pcadd8_q;
    logic [4:0]  a3_q;
    logic        memwrite_q;
    memop_t      memop_q;
    logic [31:0] sd_d;

    // No stall or flush: the register loads every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ao_q       <= '0;
            rt_q       <= '0;
            pc_q       <= '0;
            pcadd8_q   <= '0;
            a3_q       <= '0;
            memwrite_q <= 1'b0;
            memop_q    <= MEMOP_W;
        end else begin
            ao_q       <= AO_E;
            rt_q       <= RT_E;
            pc_q       <= PC_E;
            pcadd8_q   <= PCAdd8_E;
            a3_q       <= A3_E;
            memwrite_q <= MemWrite_E;
            memop_q    <= MemOp_E;
        end
    end

    // rt may have been produced by the instruction now in W.
    assign sd_d = ForwardRT_M ? WD_W : rt_q;

    data_memory #(
        .DM_WORDS (DM_WORDS),
        .DM_AW    (DM_AW)
    ) u_dm (
        .clk     (clk),
        .reset   (reset),
        .we_i    (memwrite_q),
        .memop_i (memop_q),
        .addr_i  (ao_q),
        .wd_i    (sd_d),
        .pc_i    (pc_q),
        .rd_o    (DMout_M)
    );

    assign AO_M     = ao_q;
    assign PC_M     = pc_q;
    assign PCAdd8_M = pcadd8_q;
    assign A3_M     = a3_q;

endmodule : mem_stage
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage
//  Purpose  : Self-checking bench for mem_stage. Directed instructions are
//             issued from one process; their expected M-stage outputs go into
//             a queue that a monitor drains as instructions reach M.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    localparam logic [2:0] OW = 3'd0, OH = 3'd1, OHU = 3'd2, OB = 3'd3, OBU = 3'd4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] AO_E, RT_E, PC_E, PCAdd8_E, WD_W;
    logic [4:0]  A3_E;
    logic        MemWrite_E, ForwardRT_M;
    logic [2:0]  MemOp_E;
    logic [31:0] DMout_M, AO_M, PC_M, PCAdd8_M;
    logic [4:0]  A3_M;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk         (clk),
        .reset       (reset),
        .AO_E        (AO_E),
        .RT_E        (RT_E),
        .PC_E        (PC_E),
        .PCAdd8_E    (PCAdd8_E),
        .A3_E        (A3_E),
        .MemWrite_E  (MemWrite_E),
        .MemOp_E     (MemOp_E),
        .ForwardRT_M (ForwardRT_M),
        .WD_W        (WD_W),
        .DMout_M     (DMout_M),
        .AO_M        (AO_M),
        .PC_M        (PC_M),
        .PCAdd8_M    (PCAdd8_M),
        .A3_M        (A3_M)
    );

    typedef struct {
        logic        chk_ld;
        logic [31:0] dm;
        logic [31:0] ao;
        logic [31:0] pc;
        logic [31:0] pc8;
        logic [4:0]  a3;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic        e_vld = 1'b0;
    logic        m_vld = 1'b0;
    logic [31:0] pc_n  = 32'h0040_0000;
    logic [4:0]  a3_n  = 5'd1;

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Instruction tracking mirrors the one-cycle EX->M hop.
    always @(posedge clk) m_vld <= e_vld;

    always @(negedge clk) begin
        if (m_vld) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard: got instruction in M want empty queue");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check32("AO_M", AO_M, e.ao);
                check32("PC_M", PC_M, e.pc);
                check32("PCAdd8_M", PCAdd8_M, e.pc8);
                check32("A3_M", {27'd0, A3_M}, {27'd0, e.a3});
                if (e.chk_ld) check32("DMout_M", DMout_M, e.dm);
            end
        end
    end

    // fwd/wdw are applied during this instruction's E cycle, i.e. the M cycle
    // of the previously issued instruction.
    task automatic issue(input logic wr, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] rt, input logic fwd, input logic [31:0] wdw,
                         input logic chk, input logic [31:0] exp);
        exp_t e;
        @(posedge clk);
        #1;
        AO_E        = addr;
        RT_E        = rt;
        PC_E        = pc_n;
        PCAdd8_E    = pc_n + 32'd8;
        A3_E        = a3_n;
        MemWrite_E  = wr;
        MemOp_E     = op;
        ForwardRT_M = fwd;
        WD_W        = wdw;
        e_vld       = 1'b1;
        e.chk_ld = chk; e.dm = exp; e.ao = addr; e.pc = pc_n; e.pc8 = pc_n + 32'd8; e.a3 = a3_n;
        sb.push_back(e);
        pc_n = pc_n + 32'd4;
        a3_n = a3_n + 5'd1;
    endtask

    task automatic st(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] d);
        issue(1'b1, op, addr, d, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic ld(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] exp);
        issue(1'b0, op, addr, 32'h0, 1'b0, 32'h0, 1'b1, exp);
    endtask

    task automatic idle(input logic rst);
        @(posedge clk);
        #1;
        reset       = rst;
        MemWrite_E  = 1'b0;
        ForwardRT_M = 1'b0;
        e_vld       = 1'b0;
    endtask

    initial begin
        // Reset with junk on every input, including a pending store.
        reset = 1'b1;
        AO_E = 32'h10; RT_E = 32'hFFFF_FFFF; PC_E = 32'h1234; PCAdd8_E = 32'h123C;
        A3_E = 5'd31; MemWrite_E = 1'b1; MemOp_E = OB; ForwardRT_M = 1'b1; WD_W = 32'h5555_5555;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check32("reset AO_M", AO_M, 32'h0);
        check32("reset PC_M", PC_M, 32'h0);
        check32("reset PCAdd8_M", PCAdd8_M, 32'h0);
        check32("reset A3_M", {27'd0, A3_M}, 32'h0);
        check32("reset DMout_M", DMout_M, 32'h0);
        reset = 1'b0; MemWrite_E = 1'b0; ForwardRT_M = 1'b0;

        ld(OW, 32'h0, 32'h0);
        ld(OW, 32'hFFC, 32'h0);
        // word round trip
        st(OW, 32'h10, 32'h1234_5678);
        ld(OW, 32'h10, 32'h1234_5678);
        // byte/half merge; upper bits of store data must be ignored
        st(OW, 32'h20, 32'hAABB_CCDD);
        st(OB, 32'h21, 32'hFFFF_FF11);
        st(OH, 32'h22, 32'h9999_2233);
        ld(OW, 32'h20, 32'h2233_11DD);
        // extension
        st(OW,  32'h30, 32'h80FF_7F80);
        ld(OB,  32'h30, 32'hFFFF_FF80);
        ld(OBU, 32'h30, 32'h0000_0080);
        ld(OH,  32'h32, 32'hFFFF_80FF);
        ld(OHU, 32'h32, 32'h0000_80FF);
        ld(OB,  32'h31, 32'h0000_007F);
        ld(OBU, 32'h33, 32'h0000_0080);
        ld(OH,  32'h30, 32'h0000_7F80);
        // forwarding: WD_W replaces rt during the store's M cycle
        st(OW, 32'h50, 32'h0000_0001);
        issue(1'b0, OW, 32'h50, 32'h0, 1'b1, 32'hCAFE_BABE, 1'b1, 32'hCAFE_BABE);
        // unused codes act as word; misaligned word stores truncate
        st(3'd7, 32'h60, 32'hDEAD_BEEF);
        issue(1'b0, 3'd6, 32'h61, 32'h0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        st(OW, 32'h72, 32'h0BAD_F00D);
        ld(OW, 32'h70, 32'h0BAD_F00D);
        // address wrap
        st(OW, 32'h1000, 32'h0000_0005);
        ld(OW, 32'h0, 32'h0000_0005);
        // reset in the store's M cycle: store lost, memory cleared
        st(OW, 32'h40, 32'h0000_0077);
        idle(1'b1);
        idle(1'b0);
        ld(OW, 32'h40, 32'h0);
        ld(OW, 32'h10, 32'h0);
        ld(OW, 32'h0, 32'h0);
        idle(1'b0);
        idle(1'b0);

        begin
            int n;
            n = 0;
            while (sb.size() != 0 && n < 20) begin
                @(posedge clk);
                n++;
            end
            if (sb.size() != 0) begin
                total++;
                bad++;
                $display("FAIL drain: got %0d pending want 0", sb.size());
            end
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_stage
`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage MIPS pipeline, directly upstream of the MEM/WB register (WriteBack).
- Contains the EX/MEM pipeline register, the data memory with word/half/byte load and store, and store-data forwarding from the W stage.
- Outputs DMout_M, AO_M, PC_M and PCAdd8_M feed WriteBack unchanged.
- A3_M goes to the hazard unit.

Parameters:
- DM_WORDS, 1024: data memory depth in 32-bit words; must be a power of two.
- DM_AW, 10: word-index width, equal to log2(DM_WORDS).

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears the pipeline register and the whole data memory.
- AO_E  in  32  ALU result from EX; the memory byte address for loads and stores.
- RT_E  in  32  store data (rt value) from EX.
- PC_E  in  32  instruction PC.
- PCAdd8_E  in  32  PC+8 (jal link value).
- A3_E  in  5  destination register number.
- MemWrite_E  in  1  instruction is a store.
- MemOp_E  in  3  access size/extension code.
- ForwardRT_M  in  1  from hazard unit: replace registered store data with WD_W this cycle.
- WD_W  in  32  W-stage write-back value.
- DMout_M  out  32  extended load data (combinational).
- AO_M  out  32  registered ALU result.
- PC_M  out  32  registered PC.
- PCAdd8_M  out  32  registered PC+8.
- A3_M  out  5  registered destination register.

Behaviour:
- EX/MEM register: on posedge, reset=1 clears AO, RT, PC, PCAdd8, A3, MemWrite and MemOp to 0. Otherwise all fields load from the *_E inputs. No stall and no flush input; this stage always advances.
- Initial state at time 0 equals the reset state.
- Word index: AO_M[DM_AW+1:2]. Higher address bits are ignored, so the address wraps modulo DM_WORDS*4.
- Store data: SD = ForwardRT_M ? WD_W : RT_reg.
- Store commit happens on the posedge that ends the M cycle, when registered MemWrite=1 and reset=0.
  - MEMOP_W: the full word is written. AO_M[1:0] is ignored; misaligned addresses truncate.
  - MEMOP_H / MEMOP_HU: SD[15:0] goes to half AO_M[1]. Half 0 is bits 15:0, half 1 is bits 31:16. Other bytes are preserved.
  - MEMOP_B / MEMOP_BU: SD[7:0] goes to byte lane AO_M[1:0]. Lane 0 is bits 7:0 (little-endian). Other lanes are preserved.
  - Codes 5-7 behave as MEMOP_W.
- Load (combinational from the current memory contents and AO_M):
  - MEMOP_W: the full word.
  - MEMOP_H: the selected half, sign-extended.
  - MEMOP_HU: the selected half, zero-extended.
  - MEMOP_B: the selected byte, sign-extended.
  - MEMOP_BU: the selected byte, zero-extended.
  - Codes 5-7: the full word.
- DMout_M is driven regardless of instruction type; the W stage selects whether to use it.
- Latency: a store is visible to a load one cycle later, i.e. to the next instruction entering M. The one-instruction-per-stage structure excludes a same-cycle read-after-write.
- reset together with a pending store: reset wins. Memory is all zero after that edge, and the store is lost.
- reset clears all DM_WORDS words in a single cycle. After release, every load returns 0 until written.
- Simulation-only trace on each committed store: $display("@%h: *%h <= %h", PC_M, {AO_M[31:2],2'b00}, merged_word). Excluded from synthesis.

Decomposition:
- Package mips_pkg holds:
  - the MemOp encoding: MEMOP_W=3'd0, MEMOP_H=3'd1, MEMOP_HU=3'd2, MEMOP_B=3'd3, MEMOP_BU=3'd4;
  - the DM_WORDS default.
- Sub-module data_memory contains:
  - the array;
  - reset clear;
  - byte-enable merge write;
  - size/extension read mux;
  - the store trace.
- mem_stage holds the EX/MEM register and the forwarding mux, and instantiates data_memory.

Test Plan:
- Reset: hold reset 2 cycles with nonzero *_E inputs -> AO_M=PC_M=PCAdd8_M=0, A3_M=0; a lw from 0x0 and from 0xFFC returns 0.
- Word round trip: sw 0x12345678 at 0x10, then lw 0x10 -> DMout_M=0x12345678; AO_M=0x10 and PC_M follow one cycle after the *_E inputs.
- Byte/half merge: sw 0xAABBCCDD at 0x20, sb 0x11 at 0x21, sh 0x2233 at 0x22, lw 0x20 -> 0x223311DD.
- Extension: with word 0x80FF7F80 at 0x30:
  - lb 0x30 -> 0xFFFFFF80; lbu 0x30 -> 0x00000080;
  - lh 0x32 -> 0xFFFF80FF; lhu 0x32 -> 0x000080FF.
- Forwarding: sw with RT_E=0x1, ForwardRT_M=1 and WD_W=0xCAFEBABE in its M cycle -> lw returns 0xCAFEBABE.
- Wrap and reset race:
  - sw 0x5 at 0x1000 -> lw 0x0 returns 0x5 (DM_WORDS=1024).
  - sw with reset asserted in its M cycle -> word reads 0 afterwards, and no trace line is printed.
